e_alu_issue_arb: RTL and testbench

- Shares one combinational integer ALU among REQ_NUM issue ports (e.g. two integer issue queues).
- Arbitrates requests round-robin and registers the winning operands into an issue stage that drives the ALU.
- Captures the ALU result into a writeback stage with valid/ready backpressure.
- Sits between the integer issue queues and the integer writeback/bypass network. Provides flush support for branch-mispredict and exception recovery.

---
 rtl/e_alu_issue_arb.sv | 170 +++++++++++++++++
 tb/tb_e_alu_issue_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_alu_issue_arb.sv
// Round-robin issue arbiter in front of one shared combinational integer ALU.
// S1 registers the winning operands and drives the ALU; S2 holds the result for writeback.
module e_alu_issue_arb #(
  parameter int REQ_NUM = 2,
  parameter int TAG_W   = 6,
  parameter int SRC_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic [REQ_NUM-1:0]         req_valid_i,
  output logic [REQ_NUM-1:0]         req_ready_o,
  input  logic [REQ_NUM*32-1:0]      req_r0_i,
  input  logic [REQ_NUM*32-1:0]      req_r1_i,
  input  logic [REQ_NUM*32-1:0]      req_pc_i,
  input  logic [REQ_NUM*3-1:0]       req_grand_op_i,
  input  logic [REQ_NUM*3-1:0]       req_op_i,
  input  logic [REQ_NUM*TAG_W-1:0]   req_tag_i,
  output logic [31:0]                alu_r0_o,
  output logic [31:0]                alu_r1_o,
  output logic [31:0]                alu_pc_o,
  output logic [2:0]                 alu_grand_op_o,
  output logic [2:0]                 alu_op_o,
  input  logic [31:0]                alu_result_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [31:0]                wb_result_o,
  output logic [TAG_W-1:0]           wb_tag_o,
  output logic [SRC_W-1:0]           wb_src_o,
  output logic                       busy_o
);

  logic [31:0]      r0_arr       [REQ_NUM];
  logic [31:0]      r1_arr       [REQ_NUM];
  logic [31:0]      pc_arr       [REQ_NUM];
  logic [2:0]       grand_op_arr [REQ_NUM];
  logic [2:0]       op_arr       [REQ_NUM];
  logic [TAG_W-1:0] tag_arr      [REQ_NUM];

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_unpack
    assign r0_arr[gi]       = req_r0_i[32*gi +: 32];
    assign r1_arr[gi]       = req_r1_i[32*gi +: 32];
    assign pc_arr[gi]       = req_pc_i[32*gi +: 32];
    assign grand_op_arr[gi] = req_grand_op_i[3*gi +: 3];
    assign op_arr[gi]       = req_op_i[3*gi +: 3];
    assign tag_arr[gi]      = req_tag_i[TAG_W*gi +: TAG_W];
  end

  logic             s1_valid_reg;
  logic [31:0]      s1_r0_reg;
  logic [31:0]      s1_r1_reg;
  logic [31:0]      s1_pc_reg;
  logic [2:0]       s1_grand_op_reg;
  logic [2:0]       s1_op_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic [SRC_W-1:0] s1_src_reg;
  logic             s2_valid_reg;
  logic [31:0]      s2_result_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic [SRC_W-1:0] s2_src_reg;
  logic [SRC_W-1:0] rr_ptr_reg;

  logic s2_load;
  logic s1_adv;
  logic s1_free;
  logic arb_en;

  assign s2_load = !s2_valid_reg || wb_ready_i;
  assign s1_adv  = s1_valid_reg && s2_load;
  assign s1_free = !s1_valid_reg || s1_adv;
  // rst_n gates the grant so no handshake can be seen while reset is held
  assign arb_en  = rst_n && s1_free && !flush_i;

  logic [SRC_W:0]     cand;
  logic [SRC_W-1:0]   cand_idx;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_found;
  logic [REQ_NUM-1:0] grant;
  logic [SRC_W-1:0]   rr_next;

  // Search from rr_ptr upward, wrapping at REQ_NUM (not necessarily a power of two)
  always_comb begin
    cand        = '0;
    cand_idx    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    grant       = '0;
    if (arb_en) begin
      for (int k = 0; k < REQ_NUM; k++) begin
        cand = {1'b0, rr_ptr_reg} + (SRC_W+1)'(k);
        if (cand >= (SRC_W+1)'(REQ_NUM)) begin
          cand = cand - (SRC_W+1)'(REQ_NUM);
        end
        cand_idx = cand[SRC_W-1:0];
        if (!grant_found && req_valid_i[cand_idx]) begin
          grant_found = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign rr_next = (grant_idx == SRC_W'(REQ_NUM-1)) ? '0 : grant_idx + SRC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s1_r0_reg       <= '0;
      s1_r1_reg       <= '0;
      s1_pc_reg       <= '0;
      s1_grand_op_reg <= '0;
      s1_op_reg       <= '0;
      s1_tag_reg      <= '0;
      s1_src_reg      <= '0;
      s2_valid_reg    <= 1'b0;
      s2_result_reg   <= '0;
      s2_tag_reg      <= '0;
      s2_src_reg      <= '0;
      rr_ptr_reg      <= '0;
    end else begin
      if (grant_found) begin
        s1_r0_reg       <= r0_arr[grant_idx];
        s1_r1_reg       <= r1_arr[grant_idx];
        s1_pc_reg       <= pc_arr[grant_idx];
        s1_grand_op_reg <= grand_op_arr[grant_idx];
        s1_op_reg       <= op_arr[grant_idx];
        s1_tag_reg      <= tag_arr[grant_idx];
        s1_src_reg      <= grant_idx;
        rr_ptr_reg      <= rr_next;
      end
      if (s1_adv) begin
        s2_result_reg <= alu_result_i;
        s2_tag_reg    <= s1_tag_reg;
        s2_src_reg    <= s1_src_reg;
      end
      // Flush kills both stages; a handshake in the flush cycle already completed
      if (flush_i) begin
        s1_valid_reg <= 1'b0;
        s2_valid_reg <= 1'b0;
      end else begin
        if (grant_found) begin
          s1_valid_reg <= 1'b1;
        end else if (s1_adv) begin
          s1_valid_reg <= 1'b0;
        end
        if (s1_adv) begin
          s2_valid_reg <= 1'b1;
        end else if (wb_ready_i) begin
          s2_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign req_ready_o    = grant;
  assign alu_r0_o       = s1_r0_reg;
  assign alu_r1_o       = s1_r1_reg;
  assign alu_pc_o       = s1_pc_reg;
  assign alu_grand_op_o = s1_grand_op_reg;
  assign alu_op_o       = s1_op_reg;
  assign wb_valid_o     = s2_valid_reg;
  assign wb_result_o    = s2_result_reg;
  assign wb_tag_o       = s2_tag_reg;
  assign wb_src_o       = s2_src_reg;
  assign busy_o         = s1_valid_reg || s2_valid_reg;

endmodule

// File: tb/tb_e_alu_issue_arb.sv
// Directed bench for e_alu_issue_arb: a tracker queues expected writebacks on each
// accepted request, and a monitor pops and compares on each writeback handshake.
module tb_e_alu_issue_arb;
  localparam int REQ_NUM = 2;
  localparam int TAG_W   = 6;
  localparam int SRC_W   = 1;

  localparam logic [2:0] GOP_BW  = 3'd0;
  localparam logic [2:0] GOP_INT = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     flush_i = 1'b0;
  logic [REQ_NUM-1:0]       req_valid_i = '0;
  logic [REQ_NUM-1:0]       req_ready_o;
  logic [REQ_NUM*32-1:0]    req_r0_i = '0;
  logic [REQ_NUM*32-1:0]    req_r1_i = '0;
  logic [REQ_NUM*32-1:0]    req_pc_i = '0;
  logic [REQ_NUM*3-1:0]     req_grand_op_i = '0;
  logic [REQ_NUM*3-1:0]     req_op_i = '0;
  logic [REQ_NUM*TAG_W-1:0] req_tag_i = '0;
  logic [31:0]              alu_r0_o, alu_r1_o, alu_pc_o;
  logic [2:0]               alu_grand_op_o, alu_op_o;
  logic [31:0]              alu_result_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i = 1'b0;
  logic [31:0]              wb_result_o;
  logic [TAG_W-1:0]         wb_tag_o;
  logic [SRC_W-1:0]         wb_src_o;
  logic                     busy_o;

  e_alu_issue_arb #(.REQ_NUM(REQ_NUM), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_r0_i(req_r0_i), .req_r1_i(req_r1_i), .req_pc_i(req_pc_i),
    .req_grand_op_i(req_grand_op_i), .req_op_i(req_op_i), .req_tag_i(req_tag_i),
    .alu_r0_o(alu_r0_o), .alu_r1_o(alu_r1_o), .alu_pc_o(alu_pc_o),
    .alu_grand_op_o(alu_grand_op_o), .alu_op_o(alu_op_o), .alu_result_i(alu_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
    .wb_tag_o(wb_tag_o), .wb_src_o(wb_src_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(logic [2:0] gop, logic [2:0] op,
                                            logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = a;
    if (gop == GOP_INT) begin
      case (op)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        default: r = a;
      endcase
    end else if (gop == GOP_BW) begin
      case (op)
        3'd0:    r = a & b;
        3'd1:    r = a | b;
        OP_XOR:  r = a ^ b;
        default: r = a;
      endcase
    end
    return r;
  endfunction

  always_comb alu_result_i = alu_model(alu_grand_op_o, alu_op_o, alu_r0_o, alu_r1_o);

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic [SRC_W-1:0] src;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] exp_res [REQ_NUM];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] r0, input logic [31:0] r1,
                          input logic [2:0] gop, input logic [2:0] op,
                          input logic [TAG_W-1:0] tag, input logic [31:0] res);
    req_r0_i[32*i +: 32]         = r0;
    req_r1_i[32*i +: 32]         = r1;
    req_pc_i[32*i +: 32]         = 32'h1000 + 32'(4*i);
    req_grand_op_i[3*i +: 3]     = gop;
    req_op_i[3*i +: 3]           = op;
    req_tag_i[TAG_W*i +: TAG_W]  = tag;
    exp_res[i]                   = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tracker: every accepted request becomes one expected writeback
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < REQ_NUM; i++) begin
        if (rst_n && req_valid_i[i] && req_ready_o[i]) begin
          sb_q.push_back('{res: exp_res[i], tag: req_tag_i[TAG_W*i +: TAG_W], src: SRC_W'(i)});
        end
      end
    end
  end

  // Monitor: compare on each writeback handshake
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid_o && wb_ready_i) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got result 0x%0h tag 0x%0h, want no writeback",
                   wb_result_o, wb_tag_o);
        end else begin
          e = sb_q.pop_front();
          $display("wb: result=0x%08h tag=0x%0h src=%0d", wb_result_o, wb_tag_o, wb_src_o);
          check("wb_result", 64'(wb_result_o), 64'(e.res));
          check("wb_tag", 64'(wb_tag_o), 64'(e.tag));
          check("wb_src", 64'(wb_src_o), 64'(e.src));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requesters asserting valid: nothing may be granted
    #1 rst_n = 1'b0;
    req_valid_i = 2'b11;
    wb_ready_i  = 1'b1;
    repeat (2) step();
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_alu_r0", 64'(alu_r0_o), 64'd0);
    check("rst_wb_result", 64'(wb_result_o), 64'd0);
    check("rst_wb_tag", 64'(wb_tag_o), 64'd0);
    check("rst_wb_src", 64'(wb_src_o), 64'd0);
    req_valid_i = 2'b00;
    rst_n = 1'b1;
    step();

    // Round robin with both requesters valid
    set_slot(0, 32'd1, 32'd2, GOP_INT, OP_ADD, 6'h01, 32'd3);
    set_slot(1, 32'd30, 32'd10, GOP_INT, OP_SUB, 6'h02, 32'd20);
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 64'(req_ready_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_wb_valid", 64'(wb_valid_o), (k >= 2) ? 64'd1 : 64'd0);
      step();
    end
    req_valid_i = 2'b00;
    repeat (3) step();

    // Requester 0 only, back-to-back ADD then XOR
    set_slot(0, 32'd5, 32'd7, GOP_INT, OP_ADD, 6'h11, 32'd12);
    req_valid_i = 2'b01;
    #1 check("b2b_ready0", 64'(req_ready_o), 64'd1);
    step();
    set_slot(0, 32'hF0, 32'hFF, GOP_BW, OP_XOR, 6'h22, 32'h0F);
    #1 check("b2b_ready1", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 2'b00;
    check("b2b_res0", 64'(wb_result_o), 64'd12);
    check("b2b_tag0", 64'(wb_tag_o), 64'h11);
    step();
    check("b2b_res1", 64'(wb_result_o), 64'h0F);
    check("b2b_tag1", 64'(wb_tag_o), 64'h22);
    repeat (2) step();

    // Backpressure: fill S2 and S1, then hold wb_ready_i low
    wb_ready_i = 1'b0;
    set_slot(0, 32'h100, 32'h1, GOP_INT, OP_ADD, 6'h03, 32'h101);
    req_valid_i = 2'b01;
    #1 check("bp_ready0", 64'(req_ready_o), 64'd1);
    step();
    set_slot(1, 32'hAAAA, 32'h5555, GOP_BW, OP_XOR, 6'h04, 32'hFFFF);
    req_valid_i = 2'b10;
    #1 check("bp_ready1", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready_full", 64'(req_ready_o), 64'd0);
      check("bp_wb_valid", 64'(wb_valid_o), 64'd1);
      check("bp_wb_result", 64'(wb_result_o), 64'h101);
      check("bp_wb_tag", 64'(wb_tag_o), 64'h03);
      check("bp_busy", 64'(busy_o), 64'd1);
      step();
    end
    req_valid_i = 2'b00;
    wb_ready_i  = 1'b1;
    repeat (3) step();
    check("bp_drained_busy", 64'(busy_o), 64'd0);

    // Flush with both stages full; rr_ptr left pointing at requester 1
    wb_ready_i = 1'b0;
    set_slot(0, 32'd1, 32'd1, GOP_INT, OP_ADD, 6'h05, 32'd2);
    req_valid_i = 2'b01;
    #1 check("fl_ready0", 64'(req_ready_o), 64'd1);
    step();
    set_slot(0, 32'd2, 32'd2, GOP_INT, OP_ADD, 6'h06, 32'd4);
    #1 check("fl_ready1", 64'(req_ready_o), 64'd1);
    step();
    flush_i    = 1'b1;
    wb_ready_i = 1'b1;
    #1 check("fl_ready_flush", 64'(req_ready_o), 64'd0);
    step();
    sb_q.delete();
    flush_i     = 1'b0;
    wb_ready_i  = 1'b0;
    req_valid_i = 2'b00;
    #1;
    check("fl_wb_valid", 64'(wb_valid_o), 64'd0);
    check("fl_busy", 64'(busy_o), 64'd0);
    set_slot(1, 32'd3, 32'd4, GOP_INT, OP_ADD, 6'h07, 32'd7);
    wb_ready_i  = 1'b1;
    req_valid_i = 2'b11;
    #1 check("fl_rr_kept", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = 2'b00;
    repeat (3) step();

    // Asynchronous reset mid-cycle with both stages full
    wb_ready_i = 1'b0;
    set_slot(0, 32'd10, 32'd10, GOP_INT, OP_ADD, 6'h08, 32'd20);
    set_slot(1, 32'd1, 32'd0, GOP_INT, OP_ADD, 6'h09, 32'd1);
    req_valid_i = 2'b11;
    #1 check("ar_ready0", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 2'b01;
    #1 check("ar_ready1", 64'(req_ready_o), 64'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("ar_wb_valid", 64'(wb_valid_o), 64'd0);
    check("ar_ready", 64'(req_ready_o), 64'd0);
    check("ar_busy", 64'(busy_o), 64'd0);
    sb_q.delete();
    repeat (2) step();
    req_valid_i = 2'b00;
    #2 rst_n = 1'b1;
    step();
    wb_ready_i  = 1'b1;
    req_valid_i = 2'b11;
    #1 check("ar_first_grant", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 2'b00;
    repeat (3) step();

    // Only requester 1 valid: grant 1 and wrap rr_ptr to 0
    req_valid_i = 2'b10;
    #1 check("w_ready_a", 64'(req_ready_o), 64'd2);
    step();
    #1 check("w_ready_b", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = 2'b11;
    #1 check("w_wrap", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = 2'b00;

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) step();
    repeat (2) step();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("end_busy", 64'(busy_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
